itcm_boot_loader: RTL and testbench



---
 rtl/itcm_boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_itcm_boot_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_boot_loader.sv
// ============================================================================
// Module   : itcm_boot_loader
// Brief    : Packs a boot byte stream into ITCM words and sequences core reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module itcm_boot_loader #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int RST_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_req,
    input  logic          boot_skip,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          itcm_WEN,
    output logic [AW-1:0] itcm_WADDR,
    output logic [DW-1:0] itcm_WDATA,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-2:0] words_loaded
);

    localparam int c_CW = $clog2(RST_HOLD + 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_DRAIN   = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_RUN     = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [1:0]      r_lane;
    logic [23:0]     r_pack;
    // One bit wider than the word index so "all words written" is visible
    logic [AW-2:0]   r_ptr;
    logic [c_CW-1:0] r_cnt;
    logic            r_s_ready;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_core_rst_n;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_acc;
    logic            w_load_acc;
    logic            w_full;
    logic            w_ovf;
    logic            w_write;
    logic            w_start;
    logic            w_cnt_done;
    logic [DW-1:0]   w_word;

    assign w_acc      = s_valid & r_s_ready;
    assign w_full     = r_ptr[AW-2];
    assign w_load_acc = w_acc && (r_state == c_ST_LOAD);
    assign w_ovf      = w_load_acc && w_full;
    assign w_write    = w_load_acc && !w_full && ((r_lane == 2'd3) || s_last);
    assign w_start    = boot_req && ((r_state == c_ST_IDLE) || (r_state == c_ST_RUN));
    assign w_cnt_done = (r_cnt == c_CW'(RST_HOLD));

    // Lanes above the current byte are zero-filled for a partial final word
    always_comb begin
        w_word = '0;
        case (r_lane)
            2'd0:    w_word = {24'h0, s_data};
            2'd1:    w_word = {16'h0, s_data, r_pack[7:0]};
            2'd2:    w_word = {8'h0, s_data, r_pack[15:0]};
            default: w_word = {s_data, r_pack};
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (boot_req) begin
                    w_next_state = c_ST_LOAD;
                end else if (boot_skip) begin
                    w_next_state = c_ST_RELEASE;
                end
            end
            c_ST_LOAD: begin
                if (w_acc) begin
                    if (w_full) begin
                        w_next_state = s_last ? c_ST_IDLE : c_ST_DRAIN;
                    end else if (s_last) begin
                        w_next_state = c_ST_RELEASE;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_acc && s_last) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_RELEASE: begin
                if (w_cnt_done) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (boot_req) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_s_ready    <= (w_next_state == c_ST_LOAD) || (w_next_state == c_ST_DRAIN);
            r_busy       <= (w_next_state == c_ST_LOAD) || (w_next_state == c_ST_DRAIN) ||
                            (w_next_state == c_ST_RELEASE);
            r_done       <= (w_next_state == c_ST_RUN);
            r_core_rst_n <= (w_next_state == c_ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane  <= 2'd0;
            r_pack  <= 24'h0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_write;
            if (w_start) begin
                r_lane <= 2'd0;
                r_ptr  <= '0;
                r_err  <= 1'b0;
            end else begin
                if (w_ovf) begin
                    r_err <= 1'b1;
                end
                if (w_load_acc && !w_full) begin
                    r_lane <= r_lane + 2'd1;
                    case (r_lane)
                        2'd0:    r_pack[7:0]   <= s_data;
                        2'd1:    r_pack[15:8]  <= s_data;
                        2'd2:    r_pack[23:16] <= s_data;
                        default: r_pack        <= r_pack;
                    endcase
                end
                if (w_write) begin
                    r_waddr <= {r_ptr[AW-3:0], 2'b00};
                    r_wdata <= w_word;
                    r_ptr   <= r_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == c_ST_RELEASE) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign s_ready      = r_s_ready;
    assign itcm_WEN     = r_wen;
    assign itcm_WADDR   = r_waddr;
    assign itcm_WDATA   = r_wdata;
    assign core_rst_n   = r_core_rst_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_itcm_boot_loader.sv
// ============================================================================
// Module   : tb_itcm_boot_loader
// Brief    : Scoreboard bench for itcm_boot_loader with a word-level image model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_itcm_boot_loader;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int RH  = 6;
    localparam int CAP = 1 << (AW - 2);

    logic          clk;
    logic          rst_n;
    logic          boot_req;
    logic          boot_skip;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_last;
    logic          s_ready;
    logic          itcm_WEN;
    logic [AW-1:0] itcm_WADDR;
    logic [DW-1:0] itcm_WDATA;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-2:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] last_addr = 0;
    logic [31:0] last_data = 0;

    itcm_boot_loader #(.AW(AW), .DW(DW), .RST_HOLD(RH)) dut (
        .clk(clk), .rst_n(rst_n), .boot_req(boot_req), .boot_skip(boot_skip),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .itcm_WEN(itcm_WEN), .itcm_WADDR(itcm_WADDR), .itcm_WDATA(itcm_WDATA),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard; idle outputs hold
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = 0;
            last_data = 0;
            check("wen_in_reset", {31'h0, itcm_WEN}, 32'h0);
        end else if (itcm_WEN) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_write_addr", 32'(itcm_WADDR), 32'hFFFF_FFFF);
            end else begin
                check("write_addr", 32'(itcm_WADDR), exp_addr.pop_front());
                check("write_data", itcm_WDATA, exp_data.pop_front());
            end
            last_addr = 32'(itcm_WADDR);
            last_data = itcm_WDATA;
        end else begin
            check("hold_addr", 32'(itcm_WADDR), last_addr);
            check("hold_data", itcm_WDATA, last_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic req, input logic skip);
        boot_req  = req;
        boot_skip = skip;
        tick();
        boot_req  = 1'b0;
        boot_skip = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 32'(s_ready), 32'h1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic measure_release();
        int n = 0;
        check("rel_core_rst_low", {31'h0, core_rst_n}, 32'h0);
        while (core_rst_n == 1'b0 && n < RH + 20) begin
            tick();
            n++;
        end
        check("release_latency", n, RH + 1);
        check("run_done", {31'h0, done}, 32'h1);
        check("run_busy", {31'h0, busy}, 32'h0);
    endtask

    // Reference model: the image becomes ceil(len/4) little-endian words, capped at CAP
    task automatic load(input logic gaps, input logic with_skip);
        int  len = img.size();
        bit  ovf = (len > 4 * CAP);
        int  nw  = ovf ? CAP : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d = 0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < len) d = d | (32'(img[4 * w + j]) << (8 * j));
            end
            exp_addr.push_back(32'(4 * w));
            exp_data.push_back(d);
        end
        pulse(1'b1, with_skip);
        check("start_ready", {31'h0, s_ready}, 32'h1);
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_core_rst", {31'h0, core_rst_n}, 32'h0);
        check("start_done", {31'h0, done}, 32'h0);
        check("start_err", {31'h0, err}, 32'h0);
        check("start_words", 32'(words_loaded), 32'h0);
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send(img[i], (i == len - 1));
        end
        check("end_ready", {31'h0, s_ready}, 32'h0);
        if (!ovf) begin
            measure_release();
            check("end_err", {31'h0, err}, 32'h0);
        end else begin
            repeat (RH + 4) tick();
            check("ovf_core_rst", {31'h0, core_rst_n}, 32'h0);
            check("ovf_done", {31'h0, done}, 32'h0);
            check("ovf_busy", {31'h0, busy}, 32'h0);
            check("ovf_err", {31'h0, err}, 32'h1);
        end
        check("words_loaded", 32'(words_loaded), 32'(nw));
        check("scoreboard_empty", exp_addr.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; boot_req = 1'b0; boot_skip = 1'b0;
        s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (50) begin
            tick();
            check("idle_core_rst", {31'h0, core_rst_n}, 32'h0);
            check("idle_ready", {31'h0, s_ready}, 32'h0);
            check("idle_wen", {31'h0, itcm_WEN}, 32'h0);
            check("idle_done", {31'h0, done}, 32'h0);
        end

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        load(1'b0, 1'b0);

        // From RUN: the boot_req edge must pull the core back into reset
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load(1'b0, 1'b0);

        pulse(1'b0, 1'b1);
        tick();
        check("run_skip_ignored", {31'h0, done}, 32'h1);

        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'hA0 + i));
        load(1'b0, 1'b0);

        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load(1'b0, 1'b1);

        // Mid-word asynchronous reset
        pulse(1'b1, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'h0, s_ready}, 32'h0);
        check("arst_wen", {31'h0, itcm_WEN}, 32'h0);
        check("arst_waddr", 32'(itcm_WADDR), 32'h0);
        check("arst_wdata", itcm_WDATA, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_err", {31'h0, err}, 32'h0);
        check("arst_words", 32'(words_loaded), 32'h0);
        check("arst_core_rst", {31'h0, core_rst_n}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("post_arst_idle", {31'h0, busy}, 32'h0);

        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(1'b1, 1'b0);

        // boot_skip path from IDLE
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse(1'b0, 1'b1);
        check("skip_busy", {31'h0, busy}, 32'h1);
        measure_release();

        for (int t = 0; t < 15; t++) begin
            int len = $urandom_range(1, 4 * CAP + 4);
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            load(1'b1, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        check("final_scoreboard", exp_addr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
